// File: rtl/jt900h_muldiv.sv
// Radix-2 iterative multiply/divide engine for the 900H ALU: restoring divide and shift-add multiply,
// byte (W/2) or word (W) length, signed or unsigned, with a fixed N+1 cycle latency.
module jt900h_muldiv #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           start,
  input  logic           mul,
  input  logic           sign,
  input  logic           len,
  input  logic [2*W-1:0] op0,
  input  logic [W-1:0]   op1,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] rslt,
  output logic           v
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_q, mul_d;
  logic             sign_q, sign_d;
  logic             len_q, len_d;
  logic             neg_q, neg_d;       // quotient / product is negative
  logic             rneg_q, rneg_d;     // remainder is negative
  logic             vz_q, vz_d;         // overflow known from magnitudes at start
  logic [W-1:0]     opd_q, opd_d;       // |divisor| or |multiplicand|
  logic [W-1:0]     hi_q, hi_d;         // remainder / product upper half
  logic [W-1:0]     lo_q, lo_d;         // quotient / product lower half
  logic [W-1:0]     raw_q, raw_d;       // dividend low N bits as supplied
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*W-1:0]   rslt_q, rslt_d;
  logic             v_q, v_d;

  // Operand magnitudes, sign-extended to the working width of the selected length.
  logic [2*W-1:0] dvd_sx, dvd_mag;
  logic [W-1:0]   op1_sx, op1_mag, mcd_sx, mcd_mag, dvd_hi;
  logic           dvd_neg, op1_neg, mcd_neg;

  always_comb begin
    if (len) begin
      dvd_sx  = op0;
      op1_sx  = op1;
      mcd_sx  = op0[W-1:0];
      dvd_neg = sign & op0[2*W-1];
      op1_neg = sign & op1[W-1];
      mcd_neg = sign & op0[W-1];
    end else begin
      dvd_sx  = {{W{sign & op0[W-1]}}, op0[W-1:0]};
      op1_sx  = {{H{sign & op1[H-1]}}, op1[H-1:0]};
      mcd_sx  = {{H{sign & op0[H-1]}}, op0[H-1:0]};
      dvd_neg = sign & op0[W-1];
      op1_neg = sign & op1[H-1];
      mcd_neg = sign & op0[H-1];
    end
    dvd_mag = dvd_neg ? -dvd_sx : dvd_sx;
    op1_mag = op1_neg ? -op1_sx : op1_sx;
    mcd_mag = mcd_neg ? -mcd_sx : mcd_sx;
    dvd_hi  = len ? dvd_mag[2*W-1:W] : {{H{1'b0}}, dvd_mag[W-1:H]};
  end

  // One iteration step for each operation.
  logic [W:0]   rem_sh, sum;
  logic [W-1:0] diff;
  logic         no_borrow;

  always_comb begin
    rem_sh    = {hi_q, lo_q[W-1]};
    no_borrow = rem_sh >= {1'b0, opd_q};
    diff      = W'(rem_sh - {1'b0, opd_q});
    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  end

  // Sign fix-up and overflow qualification for the final edge.
  logic [W-1:0]   quot_mag, rem_mag, quot_s, rem_s, quot_f, rem_f, lim;
  logic [2*W-1:0] prod_mag, prod_neg, prod_s, div_res;
  logic           ovf;

  always_comb begin
    quot_mag = len_q ? lo_q : {{H{1'b0}}, lo_q[H-1:0]};
    rem_mag  = len_q ? hi_q : {{H{1'b0}}, hi_q[H-1:0]};
    quot_s   = neg_q ? -quot_mag : quot_mag;
    rem_s    = rneg_q ? -rem_mag : rem_mag;
    lim      = '0;
    if (len_q) lim[W-1] = 1'b1;
    else       lim[H-1] = 1'b1;
    if (!neg_q) lim = lim - 1'b1;
    ovf      = vz_q | (sign_q & (quot_mag > lim));
    quot_f   = ovf ? '1 : quot_s;
    rem_f    = ovf ? raw_q : rem_s;
    div_res  = len_q ? {rem_f, quot_f} : {{W{1'b0}}, rem_f[H-1:0], quot_f[H-1:0]};
    prod_mag = len_q ? {hi_q, lo_q} : {{W{1'b0}}, hi_q[H-1:0], lo_q[W-1:H]};
    prod_neg = neg_q ? -prod_mag : prod_mag;
    prod_s   = len_q ? prod_neg : {{W{1'b0}}, prod_neg[W-1:0]};
  end

  always_comb begin
    // NOTE: every _d gets a default from its _q first, so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    sign_d  = sign_q;
    len_d   = len_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    vz_d    = vz_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    raw_d   = raw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rslt_d  = rslt_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ITER;
          busy_d  = 1'b1;
          cnt_d   = len ? CW'(W - 1) : CW'(H - 1);
          mul_d   = mul;
          sign_d  = sign;
          len_d   = len;
          raw_d   = len ? op0[W-1:0] : {{H{1'b0}}, op0[H-1:0]};
          if (mul) begin
            hi_d   = '0;
            lo_d   = op1_mag;
            opd_d  = mcd_mag;
            neg_d  = mcd_neg ^ op1_neg;
            rneg_d = 1'b0;
            vz_d   = 1'b0;
          end else begin
            // Byte dividends are left-justified in lo so the same shifter serves both lengths.
            hi_d   = dvd_hi;
            lo_d   = len ? dvd_mag[W-1:0] : {dvd_mag[H-1:0], {H{1'b0}}};
            opd_d  = op1_mag;
            neg_d  = dvd_neg ^ op1_neg;
            rneg_d = dvd_neg;
            vz_d   = (op1_mag == '0) | (dvd_hi >= op1_mag);
          end
        end
      end
      ITER: begin
        if (mul_q) begin
          hi_d = sum[W:1];
          lo_d = {sum[0], lo_q[W-1:1]};
        end else begin
          hi_d = no_borrow ? diff : rem_sh[W-1:0];
          lo_d = {lo_q[W-2:0], no_borrow};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        rslt_d  = mul_q ? prod_s : div_res;
        v_d     = ~mul_q & ovf;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      sign_q  <= 1'b0;
      len_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      vz_q    <= 1'b0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      raw_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rslt_q  <= '0;
      v_q     <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      sign_q  <= sign_d;
      len_q   <= len_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      vz_q    <= vz_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      raw_q   <= raw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rslt_q  <= rslt_d;
      v_q     <= v_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign rslt = rslt_q;
  assign v    = v_q;

endmodule
